// File: rtl/bin_ram_arbiter.sv
// Single-port bin RAM arbiter: display reads have absolute priority and a fixed
// 2-cycle latency; the spectrum writer is served by req/ack in the free cycles.
// Optional stall statistics are built when BIN_ARB_STATS_EN is defined.
module bin_ram_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic              clk_pixel,
   input  logic              rst_n,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef BIN_ARB_STATS_EN
   ,
   output logic [15:0]       stat_wr_stall
`endif
);

   typedef enum logic {IDLE, WACK} state_t;

   state_t              state_q, state_d;
   logic                en_d, we_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wdata_d;
   logic                rd_issue_q;
   logic [DATA_W-1:0]   rd_hold_q;

   // NOTE: every signal gets a default before the priority chain so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = IDLE;
      en_d    = 1'b0;
      we_d    = 1'b0;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      if (rd_req) begin
         en_d   = 1'b1;
         addr_d = rd_addr;
      end else if (wr_req && state_q == IDLE) begin
         en_d    = 1'b1;
         we_d    = 1'b1;
         addr_d  = wr_addr;
         wdata_d = wr_data;
         state_d = WACK;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rd_issue_q <= 1'b0;
         rd_valid   <= 1'b0;
         rd_hold_q  <= '0;
      end else begin
         state_q    <= state_d;
         mem_en     <= en_d;
         mem_we     <= we_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
         rd_issue_q <= rd_req;
         rd_valid   <= rd_issue_q;
         if (rd_valid) rd_hold_q <= mem_rdata;
      end
   end

   assign wr_ack = (state_q == WACK);

   // The RAM's own output register carries the word in the valid cycle; the
   // hold register only keeps it stable once rd_valid drops.
   assign rd_data = rd_valid ? mem_rdata : rd_hold_q;

`ifdef BIN_ARB_STATS_EN
   // Cycles lost to reads only; the mandatory gap after an ack is not a stall.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         stat_wr_stall <= '0;
      end else if (rd_req && wr_req && state_q == IDLE && stat_wr_stall != 16'hFFFF) begin
         stat_wr_stall <= stat_wr_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bin_ram_arbiter.sv
// Randomized bench for bin_ram_arbiter against a cycle-level model of the
// arbitration rules, a shadow memory and a 2-deep read delay queue.
module tb_bin_ram_arbiter;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;

   logic              clk_pixel = 1'b0;
   logic              rst_n     = 1'b0;
   logic              rd_req    = 1'b0;
   logic [ADDR_W-1:0] rd_addr   = '0;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              wr_req    = 1'b0;
   logic [ADDR_W-1:0] wr_addr   = '0;
   logic [DATA_W-1:0] wr_data   = '0;
   logic              wr_ack;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
`ifdef BIN_ARB_STATS_EN
   logic [15:0]       stat_wr_stall;
`endif

   bin_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_pixel (clk_pixel),
      .rst_n     (rst_n),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef BIN_ARB_STATS_EN
      ,
      .stat_wr_stall (stat_wr_stall)
`endif
   );

   always #5 clk_pixel = ~clk_pixel;

   // Synchronous single-port RAM with registered read data.
   logic [DATA_W-1:0] ram [512];
   always @(posedge clk_pixel) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   // Reference model state.
   typedef struct { bit v; logic [DATA_W-1:0] d; } rd_ent_t;
   logic [DATA_W-1:0] shadow [512];
   rd_ent_t           rq [$];
   bit                m_ack, m_en, m_we, m_valid;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_data;
   int unsigned       m_stat;

   int n_checks = 0;
   int n_pass   = 0;
   int n_acks   = 0;
   int n_we     = 0;
   int cur_run  = 0;
   int last_run = 0;
   int wr_todo  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_ack = 0; m_en = 0; m_we = 0; m_valid = 0;
      m_addr = '0; m_wdata = '0; m_data = '0; m_stat = 0;
      rq.delete();
      cur_run = 0;
   endtask

   task automatic check_outputs();
      check("mem_en",    32'(mem_en),    32'(m_en));
      check("mem_we",    32'(mem_we),    32'(m_we));
      check("mem_addr",  32'(mem_addr),  32'(m_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      check("wr_ack",    32'(wr_ack),    32'(m_ack));
      check("rd_valid",  32'(rd_valid),  32'(m_valid));
      check("rd_data",   32'(rd_data),   32'(m_data));
`ifdef BIN_ARB_STATS_EN
      check("stat_wr_stall", 32'(stat_wr_stall), m_stat);
`endif
   endtask

   task automatic present_new();
      wr_req  = 1'b1;
      wr_addr = ADDR_W'($urandom_range(0, 511));
      wr_data = DATA_W'($urandom_range(0, 65535));
      wr_todo--;
   endtask

   // One clock: advance the model on the inputs the last edge consumed, compare,
   // then let the writer react to the observed ack.
   task automatic cycle();
      bit      grant;
      rd_ent_t e;
      @(negedge clk_pixel);
      grant = !rd_req && wr_req && !m_ack;
      if (rd_req && wr_req && !m_ack && m_stat < 32'hFFFF) m_stat++;
      m_en = rd_req || grant;
      m_we = grant;
      if (rd_req)     m_addr = rd_addr;
      else if (grant) m_addr = wr_addr;
      if (grant) begin
         m_wdata = wr_data;
         shadow[wr_addr] = wr_data;
      end
      e.v = rd_req;
      e.d = shadow[rd_addr];
      rq.push_back(e);
      if (rq.size() > 1) begin
         e = rq.pop_front();
         m_valid = e.v;
         if (e.v) m_data = e.d;
      end
      m_ack = grant;
      check_outputs();
      if (mem_we) n_we++;
      if (rd_valid) cur_run++;
      else if (cur_run != 0) begin
         last_run = cur_run;
         cur_run  = 0;
      end
      if (wr_req && wr_ack) begin
         n_acks++;
         if (wr_todo > 0) present_new();
         else wr_req = 1'b0;
      end else if (!wr_req && wr_todo > 0) begin
         present_new();
      end
   endtask

   task automatic apply_reset();
      rst_n  = 1'b0;
      rd_req = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk_pixel);
      check_outputs();
      rst_n = 1'b1;
   endtask

   initial begin
      int a0, w0, guard;
      for (int i = 0; i < 512; i++) begin
         ram[i]    = DATA_W'(i * 37) ^ 16'h5A5A;
         shadow[i] = DATA_W'(i * 37) ^ 16'h5A5A;
      end
      model_reset();

      // Reset and idle.
      @(negedge clk_pixel);
      apply_reset();
      repeat (20) cycle();

      // Single write then read-back of the same address.
      wr_req = 1'b1; wr_addr = 9'h005; wr_data = 16'h1234;
      cycle();
      check("single_ack", 32'(wr_ack), 32'd1);
      cycle();
      check("single_ack_pulse", 32'(wr_ack), 32'd0);
      rd_req = 1'b1; rd_addr = 9'h005;
      cycle();
      rd_req = 1'b0;
      cycle();
      check("readback_valid", 32'(rd_valid), 32'd1);
      check("readback_data",  32'(rd_data),  32'h1234);
      repeat (3) cycle();

      // 480-word read burst starving a held write.
      a0 = n_acks;
      wr_req = 1'b1; wr_addr = 9'h1F0; wr_data = 16'hBEEF;
      rd_req = 1'b1;
      for (int i = 0; i < 480; i++) begin
         rd_addr = ADDR_W'(i);
         cycle();
      end
      check("burst_no_ack", 32'(n_acks - a0), 32'd0);
      rd_req = 1'b0;
      cycle();
      check("burst_late_ack", 32'(wr_ack), 32'd1);
      repeat (4) cycle();
      check("burst_run_len", 32'(last_run), 32'd480);

      // Eight streamed writes, no reads.
      a0 = n_acks; w0 = n_we;
      wr_todo = 8;
      repeat (20) cycle();
      check("stream_acks", 32'(n_acks - a0), 32'd8);
      check("stream_we",   32'(n_we - w0),   32'd8);

      // Random mix of read bursts and writer traffic.
      wr_todo = 100000;
      for (int seg = 0; seg < 20; seg++) begin
         int dens = $urandom_range(0, 4);
         repeat (100) begin
            rd_req  = ($urandom_range(0, 3) < dens);
            rd_addr = ADDR_W'($urandom_range(0, 511));
            cycle();
         end
      end
      rd_req  = 1'b0;
      wr_todo = 0;
      guard = 0;
      while (wr_req && guard < 50) begin
         cycle();
         guard++;
      end
      check("drain_writer", 32'(wr_req), 32'd0);

      // Reset with reads in flight and a pending write.
      wr_req = 1'b1; wr_addr = 9'h0AA; wr_data = 16'hC0DE;
      rd_req = 1'b1;
      repeat (5) begin
         rd_addr = ADDR_W'($urandom_range(0, 511));
         cycle();
      end
      a0 = n_acks;
      apply_reset();
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_wr_ack",   32'(wr_ack),   32'd0);
      cycle();
      check("rst_reacked", 32'(wr_ack), 32'd1);
      repeat (3) cycle();
      check("rst_ack_count", 32'(n_acks - a0), 32'd1);
      rd_req = 1'b1; rd_addr = 9'h0AA;
      cycle();
      rd_req = 1'b0;
      cycle();
      check("rst_readback", 32'(rd_data), 32'hC0DE);

`ifdef BIN_ARB_STATS_EN
      // Stall counter: exact count, then saturation.
      apply_reset();
      repeat (3) cycle();
      wr_req = 1'b1; wr_addr = 9'h011; wr_data = 16'h0F0F;
      rd_req = 1'b1;
      repeat (10) cycle();
      check("stall_10", 32'(stat_wr_stall), 32'd10);
      repeat (70000) cycle();
      check("stall_sat", 32'(stat_wr_stall), 32'hFFFF);
      rd_req = 1'b0;
      repeat (4) cycle();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
